// File: rtl/tank_pkg.sv
// Shared tank-game definitions: screen bounds, keycodes and the bullet
// launcher state encoding. The left and right tank stages both import this.
package tank_pkg;

  // Playfield size. Both bounds are exclusive.
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Keyboard codes used by the right tank.
  localparam logic [7:0] FIRE_KEY_R       = 8'h28;  // Enter
  localparam logic [7:0] TURRET_KEY_CW_R  = 8'h51;
  localparam logic [7:0] TURRET_KEY_CCW_R = 8'h52;

  // Launcher states. The S_ prefix keeps these literals from colliding
  // with the COOLDOWN timing parameter of the launcher modules.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } launcher_state_e;

endpackage

// File: rtl/bullet_bounds_check.sv
// Combinational next-position and screen-exit check for one bullet step.
// Ports:
//   pos_x_i, pos_y_i : current bullet position
//   vel_x_i, vel_y_i : two's-complement step vector
//   nx_o, ny_o       : position after the step, modulo 2^10
//   oob_o            : next position lies outside the screen
// A step that goes below zero wraps to a large unsigned value, so a single
// unsigned compare against the upper bound catches both screen edges.
module bullet_bounds_check #(
  parameter int unsigned SCREEN_W = tank_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = tank_pkg::SCREEN_H
) (
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  input  logic [9:0] vel_x_i,
  input  logic [9:0] vel_y_i,
  output logic [9:0] nx_o,
  output logic [9:0] ny_o,
  output logic       oob_o
);

  always_comb begin
    nx_o  = pos_x_i + vel_x_i;
    ny_o  = pos_y_i + vel_y_i;
    oob_o = (32'(nx_o) >= SCREEN_W) || (32'(ny_o) >= SCREEN_H);
  end

endmodule

// File: rtl/bullet_launcher_r.sv
// Right-tank bullet launcher. Latches the turret's motion vector and muzzle
// position on a fire keypress, steps the bullet once per clk2 edge and
// retires it on a hit, on leaving the screen or on reaching its lifetime,
// followed by a fixed cooldown before the next shot can be taken.
// Ports:
//   clk2          : frame tick, one edge = one bullet step
//   Reset         : synchronous, active-low
//   keycode       : current keyboard code
//   motion_x/y    : two's-complement step vector from the turret stage
//   init_x/y      : muzzle position from the turret stage
//   hit_in        : collision this step, retires the bullet
//   bullet_x/y    : current bullet position
//   bullet_active : bullet is drawn and collidable
//   busy          : launcher is FLYING or in COOLDOWN
//   shot_count    : shots fired (wraps)
//   hit_count     : flights ended by hit_in (wraps)
module bullet_launcher_r #(
  parameter logic [7:0]  FIRE_KEY = tank_pkg::FIRE_KEY_R,
  parameter int unsigned SCREEN_W = tank_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = tank_pkg::SCREEN_H,
  parameter int unsigned MAX_LIFE = 400,
  parameter int unsigned COOLDOWN = 30
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] motion_x,
  input  logic [9:0] motion_y,
  input  logic [9:0] init_x,
  input  logic [9:0] init_y,
  input  logic       hit_in,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       busy,
  output logic [7:0] shot_count,
  output logic [7:0] hit_count
);

  import tank_pkg::*;

  localparam int unsigned LIFE_W = (MAX_LIFE > 1) ? $clog2(MAX_LIFE) : 1;
  localparam int unsigned COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(MAX_LIFE - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN - 1);

  launcher_state_e   state_q;
  logic [9:0]        bullet_x_q;
  logic [9:0]        bullet_y_q;
  logic [9:0]        vel_x_q;
  logic [9:0]        vel_y_q;
  logic [LIFE_W-1:0] life_q;
  logic [COOL_W-1:0] cool_q;
  logic              armed_q;
  logic              active_q;
  logic              busy_q;
  logic [7:0]        shot_q;
  logic [7:0]        hit_q;

  logic [9:0]        nx;
  logic [9:0]        ny;
  logic              oob;
  logic              fire_key;

  assign fire_key = (keycode == FIRE_KEY);

  bullet_bounds_check #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bounds (
    .pos_x_i (bullet_x_q),
    .pos_y_i (bullet_y_q),
    .vel_x_i (vel_x_q),
    .vel_y_i (vel_y_q),
    .nx_o    (nx),
    .ny_o    (ny),
    .oob_o   (oob)
  );

  always_ff @(posedge clk2) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      bullet_x_q <= '0;
      bullet_y_q <= '0;
      vel_x_q    <= '0;
      vel_y_q    <= '0;
      life_q     <= '0;
      cool_q     <= '0;
      armed_q    <= 1'b1;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
      shot_q     <= '0;
      hit_q      <= '0;
    end else begin
      // Re-arm on any edge the fire key is not held, in every state, so a
      // held key never auto-repeats. An accepted shot below clears it; the
      // two cannot coincide because a shot requires the fire key.
      if (!fire_key) begin
        armed_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (armed_q && fire_key) begin
            state_q    <= S_FLYING;
            busy_q     <= 1'b1;
            active_q   <= 1'b1;
            armed_q    <= 1'b0;
            bullet_x_q <= init_x;
            bullet_y_q <= init_y;
            vel_x_q    <= motion_x;
            vel_y_q    <= motion_y;
            life_q     <= '0;
            shot_q     <= shot_q + 8'd1;
          end
        end

        S_FLYING: begin
          // Retire conditions in priority order; a hit always counts, even
          // when the bullet would also have left the screen this step.
          if (hit_in) begin
            state_q  <= S_COOLDOWN;
            active_q <= 1'b0;
            cool_q   <= '0;
            hit_q    <= hit_q + 8'd1;
          end else if (oob) begin
            state_q  <= S_COOLDOWN;
            active_q <= 1'b0;
            cool_q   <= '0;
          end else if (life_q == LIFE_LAST) begin
            state_q  <= S_COOLDOWN;
            active_q <= 1'b0;
            cool_q   <= '0;
          end else begin
            bullet_x_q <= nx;
            bullet_y_q <= ny;
            life_q     <= life_q + LIFE_W'(1);
          end
        end

        S_COOLDOWN: begin
          if (cool_q == COOL_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cool_q  <= '0;
          end else begin
            cool_q <= cool_q + COOL_W'(1);
          end
        end

        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          active_q <= 1'b0;
          cool_q   <= '0;
        end
      endcase
    end
  end

  assign bullet_x      = bullet_x_q;
  assign bullet_y      = bullet_y_q;
  assign bullet_active = active_q;
  assign busy          = busy_q;
  assign shot_count    = shot_q;
  assign hit_count     = hit_q;

endmodule

// File: tb/tb_bullet_launcher_r.sv
// Bench for bullet_launcher_r: a behavioural model predicts every output each
// edge, predictions are queued when stimulus is applied and compared after the
// edge; directed scenarios add fixed-value checks at the interesting points.
module tb_bullet_launcher_r;

  logic       clk2 = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] motion_x, motion_y, init_x, init_y;
  logic       hit_in;
  logic [9:0] bullet_x, bullet_y;
  logic       bullet_active, busy;
  logic [7:0] shot_count, hit_count;

  always #5 clk2 = ~clk2;

  bullet_launcher_r #(
    .FIRE_KEY (8'h28),
    .SCREEN_W (640),
    .SCREEN_H (480),
    .MAX_LIFE (400),
    .COOLDOWN (30)
  ) dut (
    .clk2          (clk2),
    .Reset         (Reset),
    .keycode       (keycode),
    .motion_x      (motion_x),
    .motion_y      (motion_y),
    .init_x        (init_x),
    .init_y        (init_y),
    .hit_in        (hit_in),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .busy          (busy),
    .shot_count    (shot_count),
    .hit_count     (hit_count)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       busy;
    logic [7:0] shot;
    logic [7:0] hit;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: 0 idle, 1 flying, 2 cooldown
  int         m_state = 0;
  logic [9:0] m_x = '0, m_y = '0, m_vx = '0, m_vy = '0;
  int         m_life = 0, m_cool = 0;
  bit         m_armed = 1'b1, m_act = 1'b0;
  logic [7:0] m_shot = '0, m_hit = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [9:0] nx, ny;
    bit         next_armed;
    if (!Reset) begin
      m_state = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
      m_life = 0; m_cool = 0; m_armed = 1; m_act = 0; m_shot = 0; m_hit = 0;
    end else begin
      next_armed = m_armed;
      if (keycode != 8'h28) next_armed = 1;
      case (m_state)
        0: if (m_armed && keycode == 8'h28) begin
             m_state = 1; m_x = init_x; m_y = init_y; m_vx = motion_x; m_vy = motion_y;
             m_life = 0; m_act = 1; m_shot = m_shot + 1; next_armed = 0;
           end
        1: begin
             nx = m_x + m_vx;
             ny = m_y + m_vy;
             if (hit_in) begin
               m_state = 2; m_act = 0; m_hit = m_hit + 1; m_cool = 0;
             end else if (int'(nx) >= 640 || int'(ny) >= 480) begin
               m_state = 2; m_act = 0; m_cool = 0;
             end else if (m_life == 399) begin
               m_state = 2; m_act = 0; m_cool = 0;
             end else begin
               m_x = nx; m_y = ny; m_life++;
             end
           end
        default: if (m_cool == 29) begin
             m_state = 0; m_cool = 0;
           end else m_cool++;
      endcase
      m_armed = next_armed;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.x = m_x; e.y = m_y; e.act = m_act; e.busy = (m_state != 0);
    e.shot = m_shot; e.hit = m_hit;
    sb.push_back(e);
    @(posedge clk2);
    #1;
    e = sb.pop_front();
    check("bullet_x", 32'(bullet_x), 32'(e.x));
    check("bullet_y", 32'(bullet_y), 32'(e.y));
    check("bullet_active", 32'(bullet_active), 32'(e.act));
    check("busy", 32'(busy), 32'(e.busy));
    check("shot_count", 32'(shot_count), 32'(e.shot));
    check("hit_count", 32'(hit_count), 32'(e.hit));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    Reset = 1'b0; keycode = 8'h00; hit_in = 1'b0;
    motion_x = '0; motion_y = '0; init_x = '0; init_y = '0;
    cyc(2);
    check("reset_active", 32'(bullet_active), 32'd0);
    check("reset_shot", 32'(shot_count), 32'd0);
    Reset = 1'b1;
    cyc(1);

    // Reset mid-flight
    init_x = 10'd100; init_y = 10'd100; motion_x = 10'd3; motion_y = 10'd1;
    keycode = 8'h28; cyc(1);
    keycode = 8'h00; cyc(5);
    check("midflight_x", 32'(bullet_x), 32'd115);
    Reset = 1'b0; cyc(1);
    check("rst_mid_active", 32'(bullet_active), 32'd0);
    check("rst_mid_x", 32'(bullet_x), 32'd0);
    check("rst_mid_y", 32'(bullet_y), 32'd0);
    check("rst_mid_shot", 32'(shot_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    Reset = 1'b1; cyc(1);

    // Leftward shot to the screen edge, fire key held throughout
    init_x = 10'd510; init_y = 10'd420; motion_x = 10'h3FE; motion_y = 10'd0;
    keycode = 8'h28; cyc(1);
    check("launch_x", 32'(bullet_x), 32'd510);
    check("launch_active", 32'(bullet_active), 32'd1);
    cyc(255);
    check("edge_x", 32'(bullet_x), 32'd0);
    check("edge_active", 32'(bullet_active), 32'd1);
    cyc(1);
    check("retire_x", 32'(bullet_x), 32'd0);
    check("retire_active", 32'(bullet_active), 32'd0);
    cyc(35);
    check("hold_no_repeat", 32'(shot_count), 32'd1);
    keycode = 8'h00; cyc(1);
    keycode = 8'h28; cyc(1);
    check("second_shot", 32'(shot_count), 32'd2);
    keycode = 8'h00; cyc(300);

    // Upward shot hit on the third step
    init_x = 10'd558; init_y = 10'd422; motion_x = 10'd0; motion_y = 10'h3FE;
    keycode = 8'h28; cyc(1);
    keycode = 8'h00; cyc(2);
    hit_in = 1'b1; cyc(1);
    hit_in = 1'b0;
    check("hit_active", 32'(bullet_active), 32'd0);
    check("hit_y", 32'(bullet_y), 32'd418);
    check("hit_count", 32'(hit_count), 32'd1);
    hit_in = 1'b1; cyc(29);  // hits during cooldown are ignored
    hit_in = 1'b0;
    check("cool_busy", 32'(busy), 32'd1);
    cyc(1);
    check("cool_done", 32'(busy), 32'd0);

    // Turret rotates mid-flight; trajectory keeps the latched vector
    init_x = 10'd100; init_y = 10'd100; motion_x = 10'd2; motion_y = 10'd0;
    keycode = 8'h28; cyc(1);
    keycode = 8'h00; motion_x = 10'd0; motion_y = 10'd2; cyc(3);
    check("latched_x", 32'(bullet_x), 32'd106);
    check("latched_y", 32'(bullet_y), 32'd100);
    cyc(305);

    // Zero vector lives exactly MAX_LIFE flight edges
    init_x = 10'd300; init_y = 10'd200; motion_x = 10'd0; motion_y = 10'd0;
    keycode = 8'h28; cyc(1);
    keycode = 8'h00; cyc(399);
    check("life_399", 32'(bullet_active), 32'd1);
    cyc(1);
    check("life_400", 32'(bullet_active), 32'd0);
    cyc(31);

    // Hit and out-of-bounds on the same edge count once
    init_x = 10'd639; init_y = 10'd10; motion_x = 10'd1; motion_y = 10'd0;
    keycode = 8'h28; cyc(1);
    keycode = 8'h00; hit_in = 1'b1; cyc(1);
    hit_in = 1'b0;
    check("hit_oob_count", 32'(hit_count), 32'd2);
    check("hit_oob_x", 32'(bullet_x), 32'd639);
    cyc(31);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 7);
      keycode = (r < 3) ? 8'h28 : (r == 3) ? 8'h51 : (r == 4) ? 8'h52 : 8'h00;
      hit_in = ($urandom_range(0, 15) == 0);
      Reset = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) begin
        motion_x = 10'($urandom_range(0, 8)) - 10'd4;
        motion_y = 10'($urandom_range(0, 8)) - 10'd4;
        init_x = 10'($urandom_range(0, 639));
        init_y = 10'($urandom_range(0, 479));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
